rr_busarb: RTL and testbench

//  N-master round-robin bus arbiter for the shared system bus; successor to the 2-master busarb.

---
 rtl/rr_busarb.sv | 156 +++++++++++++++
 tb/tb_rr_busarb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_busarb.sv
// rr_busarb: N-master round-robin bus arbiter with active-low request/grant.
// One dead (all-grants-high) cycle is inserted between owners, and the grant
// stays parked on the last owner while nobody else is asking for the bus.
// Optional owner-tenure timeout is compiled in with `define BUSARB_TIMEOUT_EN;
// without it the owner keeps the bus for as long as it requests and blk_ is
// ignored.
module rr_busarb #(
   parameter int N_MASTERS  = 4,
   parameter int MAX_TENURE = 8,
   parameter int TENURE_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MASTERS-1:0]         breq_,
   input  logic [N_MASTERS-1:0]         blk_,
   output logic [N_MASTERS-1:0]         bgrt_,
   output logic [$clog2(N_MASTERS)-1:0] owner,
   output logic                         handover
);

   localparam int IDX_W = $clog2(N_MASTERS);

   typedef enum logic {
      ST_GRANT    = 1'b0,
      ST_HANDOVER = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     owner_reg, owner_next;
   logic [N_MASTERS-1:0] bgrt_reg, bgrt_next;
   logic                 handover_reg, handover_next;

   logic [N_MASTERS-1:0] req;        // active-high view of breq_
   logic [N_MASTERS-1:0] rot;        // requests rotated so bit 0 is the owner
   logic                 owner_req;  // current owner is requesting
   logic                 others;     // some master other than the owner requests
   logic [IDX_W-1:0]     scan_off;   // distance from owner to the next winner
   logic [IDX_W-1:0]     scan_idx;   // absolute index of the next winner
   logic [IDX_W:0]       scan_sum;
   logic                 preempt;    // tenure expired and owner is not locked

   assign req = ~breq_;

   // Rotate the request vector so that rot[k] is master (owner + k) mod N.
   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_rot
         logic [IDX_W:0]   sum;
         logic [IDX_W-1:0] idx;
         assign sum = {1'b0, owner_reg} + (IDX_W+1)'(gi);
         assign idx = (sum >= (IDX_W+1)'(N_MASTERS))
                    ? IDX_W'(sum - (IDX_W+1)'(N_MASTERS))
                    : sum[IDX_W-1:0];
         assign rot[gi] = req[idx];
      end
   endgenerate

   assign owner_req = rot[0];

   // Find the nearest requester after the owner; the owner itself is never a candidate.
   always_comb begin
      scan_off = '0;
      others   = 1'b0;
      for (int i = N_MASTERS - 1; i >= 1; i--) begin
         if (rot[i]) begin
            scan_off = IDX_W'(i);
            others   = 1'b1;
         end
      end
      scan_sum = {1'b0, owner_reg} + {1'b0, scan_off};
      scan_idx = (scan_sum >= (IDX_W+1)'(N_MASTERS))
               ? IDX_W'(scan_sum - (IDX_W+1)'(N_MASTERS))
               : scan_sum[IDX_W-1:0];
   end

`ifdef BUSARB_TIMEOUT_EN
   logic [TENURE_W-1:0] tenure_reg, tenure_next;
   logic                tenure_at_max;

   assign tenure_at_max = (tenure_reg == TENURE_W'(MAX_TENURE - 1));
   assign preempt       = tenure_at_max & blk_[owner_reg];

   // Tenure counts contested GRANT cycles; it holds at the limit while the owner is locked.
   always_comb begin
      tenure_next = '0;
      if (state_reg == ST_GRANT && owner_req && others && !preempt) begin
         tenure_next = tenure_at_max ? tenure_reg : tenure_reg + TENURE_W'(1);
      end
   end

   // Tenure counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         tenure_reg <= '0;
      end else begin
         tenure_reg <= tenure_next;
      end
   end
`else
   logic unused_blk;
   assign unused_blk = ^blk_;
   assign preempt    = 1'b0;
`endif

   // State register; outputs are registered alongside so they never depend on live inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_GRANT;
         owner_reg    <= '0;
         bgrt_reg     <= ~N_MASTERS'(1);
         handover_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         bgrt_reg     <= bgrt_next;
         handover_reg <= handover_next;
      end
   end

   // Next-state: leave GRANT only when someone else wants the bus and the owner
   // has released it (or its tenure expired); HANDOVER always lasts one cycle.
   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      case (state_reg)
         ST_GRANT: begin
            if (others && (!owner_req || preempt)) begin
               state_next = ST_HANDOVER;
               owner_next = scan_idx;
            end
         end
         ST_HANDOVER: begin
            state_next = ST_GRANT;
         end
         default: begin
            state_next = ST_GRANT;
         end
      endcase
   end

   // Output decode from the next state, captured by the state register.
   always_comb begin
      bgrt_next     = '1;
      handover_next = 1'b0;
      if (state_next == ST_GRANT) begin
         bgrt_next = ~(N_MASTERS'(1) << owner_next);
      end else begin
         handover_next = 1'b1;
      end
   end

   assign bgrt_    = bgrt_reg;
   assign owner    = owner_reg;
   assign handover = handover_reg;

endmodule

// File: tb/tb_rr_busarb.sv
// tb_rr_busarb: self-checking bench for rr_busarb (N_MASTERS=4, MAX_TENURE=8).
// A vector table covers reset, handover, wrap, parking and priority cases;
// hand-written sequences cover the rotation and (with BUSARB_TIMEOUT_EN) the
// tenure timeout. Expected outputs go through a scoreboard queue.
module tb_rr_busarb;

   logic       clk;
   logic       reset;
   logic [3:0] breq_;
   logic [3:0] blk_;
   logic [3:0] bgrt_;
   logic [1:0] owner;
   logic       handover;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic       rst;
      logic [3:0] breq;
      logic [3:0] blk;
      logic [3:0] bgrt;
      logic [1:0] own;
      logic       ho;
   } vec_t;

   typedef struct {
      logic [3:0] bgrt;
      logic [1:0] own;
      logic       ho;
      int         tag;
   } exp_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC];
   exp_t sb_q [$];

   rr_busarb #(
      .N_MASTERS (4),
      .MAX_TENURE(8),
      .TENURE_W  (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .breq_   (breq_),
      .blk_    (blk_),
      .bgrt_   (bgrt_),
      .owner   (owner),
      .handover(handover)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic check_out();
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got bgrt_=%b owner=%0d handover=%b, need an expectation",
                  bgrt_, owner, handover);
      end else begin
         e = sb_q.pop_front();
         if (bgrt_ !== e.bgrt || owner !== e.own || handover !== e.ho) begin
            n_fail++;
            $display("FAIL txn_%0d: got bgrt_=%b owner=%0d handover=%b, need bgrt_=%b owner=%0d handover=%b",
                     e.tag, bgrt_, owner, handover, e.bgrt, e.own, e.ho);
         end else begin
            $display("txn %0d: reset=%b breq_=%b blk_=%b -> bgrt_=%b owner=%0d handover=%b ok",
                     e.tag, reset, breq_, blk_, bgrt_, owner, handover);
         end
      end
   endtask

   // Drive one cycle of inputs, queue what must appear after the edge, then check.
   task automatic apply(input logic r, input logic [3:0] bq, input logic [3:0] bl,
                        input logic [3:0] eg, input logic [1:0] eo, input logic eh,
                        input int tag);
      exp_t e;
      @(negedge clk);
      reset = r;
      breq_ = bq;
      blk_  = bl;
      e.bgrt = eg;
      e.own  = eo;
      e.ho   = eh;
      e.tag  = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      int         p;
      int         n;
      logic [3:0] rel;
      logic [3:0] g;

      reset = 1'b1;
      breq_ = 4'b1111;
      blk_  = 4'b1111;

      //           rst   breq     blk      bgrt     own  ho
      vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0}; // reset
      vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0}; // idle, parked on 0
      vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b1110, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 4'b0101, 4'b1111, 4'b1111, 2'd1, 1'b1}; // masters 1,3 -> 1
      vecs[5]  = '{1'b0, 4'b0101, 4'b1111, 4'b1101, 2'd1, 1'b0};
      vecs[6]  = '{1'b0, 4'b0101, 4'b0000, 4'b1101, 2'd1, 1'b0}; // owner holds
      vecs[7]  = '{1'b0, 4'b0111, 4'b1111, 4'b1111, 2'd3, 1'b1}; // 1 releases -> 3
      vecs[8]  = '{1'b0, 4'b0111, 4'b1111, 4'b0111, 2'd3, 1'b0};
      vecs[9]  = '{1'b0, 4'b1110, 4'b1111, 4'b1111, 2'd0, 1'b1}; // wrap 3 -> 0
      vecs[10] = '{1'b0, 4'b1110, 4'b1111, 4'b1110, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 4'b1110, 4'b1111, 4'b1110, 2'd0, 1'b0};
      vecs[12] = '{1'b0, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0}; // parked
      vecs[13] = '{1'b0, 4'b1110, 4'b1111, 4'b1110, 2'd0, 1'b0}; // 0-cycle re-access
      vecs[14] = '{1'b0, 4'b1101, 4'b1111, 4'b1111, 2'd1, 1'b1};
      vecs[15] = '{1'b0, 4'b1111, 4'b1111, 4'b1101, 2'd1, 1'b0}; // granted after drop
      vecs[16] = '{1'b0, 4'b1111, 4'b1111, 4'b1101, 2'd1, 1'b0}; // parked on 1
      vecs[17] = '{1'b0, 4'b0000, 4'b0000, 4'b1101, 2'd1, 1'b0}; // all request, 1 holds
      vecs[18] = '{1'b0, 4'b0010, 4'b1111, 4'b1111, 2'd2, 1'b1}; // 1 releases -> 2
      vecs[19] = '{1'b0, 4'b0000, 4'b1111, 4'b1011, 2'd2, 1'b0};
      vecs[20] = '{1'b0, 4'b0100, 4'b1111, 4'b1111, 2'd3, 1'b1}; // 2 releases -> 3
      vecs[21] = '{1'b0, 4'b0100, 4'b1111, 4'b0111, 2'd3, 1'b0};
      vecs[22] = '{1'b0, 4'b1011, 4'b1111, 4'b1111, 2'd2, 1'b1}; // handover to 2
      vecs[23] = '{1'b1, 4'b1011, 4'b1111, 4'b1110, 2'd0, 1'b0}; // reset wins
      vecs[24] = '{1'b0, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0};
      vecs[25] = '{1'b0, 4'b0000, 4'b1111, 4'b1110, 2'd0, 1'b0};
      vecs[26] = '{1'b0, 4'b0001, 4'b1111, 4'b1111, 2'd1, 1'b1}; // 1,2,3 -> 1
      vecs[27] = '{1'b0, 4'b0001, 4'b1111, 4'b1101, 2'd1, 1'b0};

      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i].rst, vecs[i].breq, vecs[i].blk,
               vecs[i].bgrt, vecs[i].own, vecs[i].ho, i);
      end

      // Rotation: everyone requests, each owner releases after 2 granted cycles.
      apply(1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0, 100);
      p = 0;
      for (int t = 0; t < 8; t++) begin
         n   = (p + 1) % 4;
         rel = 4'b0001 << p;
         g   = ~(4'b0001 << n);
         apply(1'b0, 4'b0000, 4'b1111, ~(4'b0001 << p), 2'(p), 1'b0, 200 + 3*t);
         apply(1'b0, rel,     4'b1111, 4'b1111,         2'(n), 1'b1, 201 + 3*t);
         apply(1'b0, 4'b0000, 4'b1111, g,               2'(n), 1'b0, 202 + 3*t);
         p = n;
      end

`ifdef BUSARB_TIMEOUT_EN
      // Contested tenure expires after 8 granted cycles.
      apply(1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0, 300);
      apply(1'b0, 4'b1110, 4'b1111, 4'b1110, 2'd0, 1'b0, 301);
      for (int i = 0; i < 7; i++) begin
         apply(1'b0, 4'b1010, 4'b1111, 4'b1110, 2'd0, 1'b0, 302 + i);
      end
      apply(1'b0, 4'b1010, 4'b1111, 4'b1111, 2'd2, 1'b1, 309);
      apply(1'b0, 4'b1010, 4'b1111, 4'b1011, 2'd2, 1'b0, 310);

      // Locked owner is not preempted; release of the lock preempts at once.
      apply(1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0, 400);
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, 4'b1010, 4'b1110, 4'b1110, 2'd0, 1'b0, 401 + i);
      end
      apply(1'b0, 4'b1010, 4'b1111, 4'b1111, 2'd2, 1'b1, 413);
      apply(1'b0, 4'b1010, 4'b1111, 4'b1011, 2'd2, 1'b0, 414);
`else
      // Without the timeout a requesting owner keeps the bus indefinitely.
      apply(1'b1, 4'b1111, 4'b1111, 4'b1110, 2'd0, 1'b0, 300);
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, 4'b1010, 4'b1111, 4'b1110, 2'd0, 1'b0, 301 + i);
      end
      apply(1'b0, 4'b1011, 4'b1111, 4'b1111, 2'd2, 1'b1, 313);
      apply(1'b0, 4'b1011, 4'b1111, 4'b1011, 2'd2, 1'b0, 314);
`endif

      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, need 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
